// File: rtl/insn_parcel_buffer.sv
// Circular parcel queue between fetch and decode; assembles RVC or 32-bit
// instructions at the head, including ones that straddle fetch blocks.
module insn_parcel_buffer #(
  parameter int ENTRY_COUNT = 8,
  parameter int ENQ_PARCELS = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             flush,
  input  logic                             enqValid,
  output logic                             enqReady,
  input  logic [ADDR_WIDTH-1:0]            enqPc,
  input  logic [$clog2(ENQ_PARCELS)-1:0]   enqStartIndex,
  input  logic                             enqFault,
  input  logic [16*ENQ_PARCELS-1:0]        enqData,
  output logic                             deqValid,
  input  logic                             deqReady,
  output logic [ADDR_WIDTH-1:0]            deqPc,
  output logic [31:0]                      deqInsn,
  output logic                             deqIsCompressed,
  output logic                             deqFault,
  output logic [$clog2(ENTRY_COUNT):0]     entryCount
);

  localparam int PTR_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]           parcel_q [ENTRY_COUNT];
  logic [ADDR_WIDTH-1:0] pc_q     [ENTRY_COUNT];
  logic                  fault_q  [ENTRY_COUNT];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq_fire, deq_fire;
  logic [CNT_W-1:0] enq_n, deq_size;
  logic [PTR_W-1:0] next_idx;
  logic             is_wide;

  logic                  wr_en  [ENQ_PARCELS];
  logic [PTR_W-1:0]      wr_idx [ENQ_PARCELS];
  logic [ADDR_WIDTH-1:0] wr_pc  [ENQ_PARCELS];

  // Readiness looks only at registered occupancy so fetch never sees a path from decode.
  assign enqReady   = count_q <= CNT_W'(ENTRY_COUNT - ENQ_PARCELS);
  assign enq_fire   = enqValid && enqReady && !flush;
  assign enq_n      = CNT_W'(ENQ_PARCELS) - CNT_W'(enqStartIndex);
  assign entryCount = count_q;
  assign next_idx   = head_q + PTR_W'(1);

  always_comb begin
    for (int k = 0; k < ENQ_PARCELS; k++) begin
      wr_en[k]  = enq_fire && (k >= int'(enqStartIndex));
      wr_idx[k] = tail_q + PTR_W'(k) - PTR_W'(enqStartIndex);
      wr_pc[k]  = enqPc + ((ADDR_WIDTH'(k) - ADDR_WIDTH'(enqStartIndex)) << 1);
    end
  end

  // Head decode; every output is forced to zero while nothing complete is present.
  always_comb begin
    is_wide         = !fault_q[head_q] && (parcel_q[head_q][1:0] == 2'b11);
    deq_size        = is_wide ? CNT_W'(2) : CNT_W'(1);
    deqValid        = (count_q != '0) && (!is_wide || (count_q >= CNT_W'(2)));
    deqPc           = '0;
    deqInsn         = '0;
    deqIsCompressed = 1'b0;
    deqFault        = 1'b0;
    if (deqValid) begin
      deqPc           = pc_q[head_q];
      deqIsCompressed = !is_wide;
      if (fault_q[head_q]) begin
        deqFault = 1'b1;
      end else if (is_wide) begin
        deqInsn  = {parcel_q[next_idx], parcel_q[head_q]};
        deqFault = fault_q[next_idx];
      end else begin
        deqInsn = {16'h0, parcel_q[head_q]};
      end
    end
  end

  assign deq_fire = deqValid && deqReady && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(enq_n);
      if (deq_fire) head_d = head_q + PTR_W'(deq_size);
      count_d = count_q + (enq_fire ? enq_n : '0) - (deq_fire ? deq_size : '0);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_PARCELS; k++) begin
      if (wr_en[k]) begin
        parcel_q[wr_idx[k]] <= enqData[16*k +: 16];
        pc_q[wr_idx[k]]     <= wr_pc[k];
        fault_q[wr_idx[k]]  <= enqFault;
      end
    end
  end

endmodule

// File: tb/tb_insn_parcel_buffer.sv
// Scoreboard bench for insn_parcel_buffer: a parcel-queue reference model
// assembles expected instructions; a negedge monitor compares and retires them.
module tb_insn_parcel_buffer;
  localparam int E  = 8;
  localparam int P  = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstN;
  logic          flush;
  logic          enqValid;
  logic          enqReady;
  logic [AW-1:0] enqPc;
  logic [0:0]    enqStartIndex;
  logic          enqFault;
  logic [31:0]   enqData;
  logic          deqValid;
  logic          deqReady;
  logic [AW-1:0] deqPc;
  logic [31:0]   deqInsn;
  logic          deqIsCompressed;
  logic          deqFault;
  logic [3:0]    entryCount;

  insn_parcel_buffer #(.ENTRY_COUNT(E), .ENQ_PARCELS(P), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .enqValid(enqValid), .enqReady(enqReady),
    .enqPc(enqPc), .enqStartIndex(enqStartIndex), .enqFault(enqFault), .enqData(enqData),
    .deqValid(deqValid), .deqReady(deqReady), .deqPc(deqPc), .deqInsn(deqInsn),
    .deqIsCompressed(deqIsCompressed), .deqFault(deqFault), .entryCount(entryCount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic fault; logic [15:0] parcel; } parcel_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; logic comp; logic fault; int size; } insn_t;

  parcel_t mq[$];
  parcel_t pend[$];
  insn_t   xq[$];
  int      cnt = 0;
  int      n_checks = 0;
  int      n_pass = 0;
  logic    mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Turn leading stored parcels into complete instructions, in program order.
  task automatic assemble();
    insn_t it;
    while (mq.size() > 0) begin
      if (mq[0].fault) begin
        it = '{mq[0].pc, 32'h0, 1'b1, 1'b1, 1};
        void'(mq.pop_front());
      end else if (mq[0].parcel[1:0] != 2'b11) begin
        it = '{mq[0].pc, {16'h0, mq[0].parcel}, 1'b1, 1'b0, 1};
        void'(mq.pop_front());
      end else if (mq.size() >= 2) begin
        it = '{mq[0].pc, {mq[1].parcel, mq[0].parcel}, 1'b0, mq[1].fault, 2};
        void'(mq.pop_front());
        void'(mq.pop_front());
      end else begin
        break;
      end
      xq.push_back(it);
    end
  endtask

  // One clock cycle of stimulus; the model absorbs the enqueue/flush after the edge.
  task automatic drive(input logic ev, input logic [0:0] st, input logic [31:0] pc,
                       input logic flt, input logic [31:0] data, input logic dr, input logic fl);
    logic pflush;
    enqValid = ev; enqStartIndex = st; enqPc = pc; enqFault = flt;
    enqData = data; deqReady = dr; flush = fl;
    pend.delete();
    pflush = fl;
    if (ev && (E - cnt) >= P && !fl) begin
      for (int k = int'(st); k < P; k++) begin
        parcel_t p;
        p.pc = pc + 32'(2 * (k - int'(st)));
        p.fault = flt;
        p.parcel = data[16*k +: 16];
        pend.push_back(p);
      end
    end
    @(posedge clk);
    #1;
    if (pflush) begin
      mq.delete(); xq.delete(); cnt = 0;
    end else begin
      foreach (pend[i]) mq.push_back(pend[i]);
      cnt += pend.size();
    end
    assemble();
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, dr, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("entryCount", 64'(entryCount), 64'(cnt));
      chk("enqReady", 64'(enqReady), 64'((E - cnt) >= P));
      if (xq.size() > 0) begin
        chk("deqValid", 64'(deqValid), 64'd1);
        chk("deqPc", 64'(deqPc), 64'(xq[0].pc));
        chk("deqInsn", 64'(deqInsn), 64'(xq[0].insn));
        chk("deqIsCompressed", 64'(deqIsCompressed), 64'(xq[0].comp));
        chk("deqFault", 64'(deqFault), 64'(xq[0].fault));
        if (deqReady && !flush) begin
          cnt -= xq[0].size;
          void'(xq.pop_front());
        end
      end else begin
        chk("deqValid_idle", 64'(deqValid), 64'd0);
      end
    end
  end

  function automatic logic [15:0] rand_parcel();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(1, 0) == 1) r[1:0] = 2'b11;
    return r;
  endfunction

  initial begin
    rstN = 1'b0; flush = 1'b0; enqValid = 1'b0; enqPc = '0; enqStartIndex = '0;
    enqFault = 1'b0; enqData = '0; deqReady = 1'b0;
    #3;
    chk("rst_entryCount", 64'(entryCount), 64'd0);
    chk("rst_enqReady", 64'(enqReady), 64'd1);
    chk("rst_deqValid", 64'(deqValid), 64'd0);
    chk("rst_deqPc", 64'(deqPc), 64'd0);
    chk("rst_deqInsn", 64'(deqInsn), 64'd0);
    @(posedge clk); #2 rstN = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    // 32-bit instruction from one block
    drive(1'b1, 1'b0, 32'h80000000, 1'b0, {16'h0013, 16'h0513}, 1'b0, 1'b0);
    chk("t1_valid", 64'(deqValid), 64'd1);
    chk("t1_insn", 64'(deqInsn), 64'h00130513);
    chk("t1_comp", 64'(deqIsCompressed), 64'd0);
    chk("t1_pc", 64'(deqPc), 64'h80000000);
    chk("t1_count", 64'(entryCount), 64'd2);
    idle(1'b1);
    chk("t1_count_after", 64'(entryCount), 64'd0);

    // two RVC instructions
    drive(1'b1, 1'b0, 32'h80000000, 1'b0, {16'h4505, 16'h4501}, 1'b0, 1'b0);
    chk("t2_insn0", 64'(deqInsn), 64'h00004501);
    idle(1'b1);
    chk("t2_insn1", 64'(deqInsn), 64'h00004505);
    chk("t2_pc1", 64'(deqPc), 64'h80000002);
    idle(1'b1);

    // straddling 32-bit instruction
    drive(1'b1, 1'b1, 32'h80000002, 1'b0, {16'h0513, 16'hffff}, 1'b1, 1'b0);
    chk("t3_wait_valid", 64'(deqValid), 64'd0);
    chk("t3_wait_count", 64'(entryCount), 64'd1);
    drive(1'b1, 1'b0, 32'h80000004, 1'b0, {16'h0001, 16'h0013}, 1'b0, 1'b0);
    chk("t3_insn", 64'(deqInsn), 64'h00130513);
    chk("t3_pc", 64'(deqPc), 64'h80000002);
    repeat (2) idle(1'b1);

    // fill to capacity, extra enqueue ignored
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, 32'h80001000 + 32'(4 * i), 1'b0, {16'h0013, 16'h0513}, 1'b0, 1'b0);
    chk("t4_full_count", 64'(entryCount), 64'd8);
    chk("t4_full_ready", 64'(enqReady), 64'd0);
    drive(1'b1, 1'b0, 32'h90000000, 1'b0, {16'h4501, 16'h4501}, 1'b0, 1'b0);
    chk("t4_ignored", 64'(entryCount), 64'd8);
    idle(1'b1);
    chk("t4_count6", 64'(entryCount), 64'd6);
    chk("t4_ready", 64'(enqReady), 64'd1);
    repeat (3) idle(1'b1);

    // faulted block, then faulted high parcel of a 32-bit instruction
    drive(1'b1, 1'b0, 32'h80002000, 1'b1, {16'h0013, 16'h0513}, 1'b0, 1'b0);
    chk("t5_fault", 64'(deqFault), 64'd1);
    chk("t5_insn", 64'(deqInsn), 64'd0);
    idle(1'b1);
    chk("t5_one_parcel", 64'(entryCount), 64'd1);
    idle(1'b1);
    drive(1'b1, 1'b1, 32'h80003002, 1'b0, {16'h0513, 16'h0000}, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h80003004, 1'b1, {16'h0001, 16'h0013}, 1'b0, 1'b0);
    chk("t5_hi_fault", 64'(deqFault), 64'd1);
    chk("t5_hi_insn", 64'(deqInsn), 64'h00130513);
    repeat (3) idle(1'b1);

    // flush racing enqueue and dequeue
    drive(1'b1, 1'b0, 32'h80004000, 1'b0, {16'h4501, 16'h4501}, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h80004004, 1'b0, {16'h4501, 16'h4501}, 1'b1, 1'b1);
    chk("t6_count", 64'(entryCount), 64'd0);
    chk("t6_valid", 64'(deqValid), 64'd0);
    chk("t6_ready", 64'(enqReady), 64'd1);

    // 32-bit instruction occupying entries 7 and 0
    drive(1'b1, 1'b1, 32'h80005000, 1'b0, {16'h4501, 16'h0000}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 32'h80005002 + 32'(4 * i), 1'b0, {16'h4505, 16'h4501}, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    drive(1'b1, 1'b0, 32'h80006000, 1'b0, {16'h0013, 16'h0513}, 1'b0, 1'b0);
    repeat (4) idle(1'b1);
    chk("t7_wrap_insn", 64'(deqInsn), 64'h00130513);
    chk("t7_wrap_pc", 64'(deqPc), 64'h80006000);
    idle(1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++)
      drive(1'($urandom_range(9, 0) < 7), 1'($urandom_range(1, 0)),
            {31'($urandom), 1'b0}, 1'($urandom_range(15, 0) == 0),
            {rand_parcel(), rand_parcel()}, 1'($urandom_range(9, 0) < 6),
            1'($urandom_range(31, 0) == 0));

    // asynchronous reset mid-stream
    drive(1'b1, 1'b0, 32'h80007000, 1'b0, {16'h4501, 16'h0013}, 1'b0, 1'b0);
    mon_en = 1'b0;
    enqValid = 1'b0; deqReady = 1'b0; flush = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("arst_count", 64'(entryCount), 64'd0);
    chk("arst_valid", 64'(deqValid), 64'd0);
    chk("arst_ready", 64'(enqReady), 64'd1);
    chk("arst_insn", 64'(deqInsn), 64'd0);
    mq.delete(); xq.delete(); cnt = 0;
    #2 rstN = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    for (int c = 0; c < 200; c++)
      drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), {31'($urandom), 1'b0},
            1'b0, {rand_parcel(), rand_parcel()}, 1'($urandom_range(1, 0)), 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
